uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
Frame-level controller that sits above the UART receive top module. It holds and drives that module's baud-rate and parity configuration. It sequences raw received bytes into frames of the form `HDR, LEN, payload[LEN], CSUM` and buffers the payload. It releases the payload on a valid/ready stream only after the checksum passes, and reports length, checksum and inter-byte timeout errors.

Parameters:
- MAX_LEN, 16, payload buffer depth in bytes (max accepted LEN).
- TIMEOUT_CYC, 100000, idle clk cycles allowed between bytes inside a frame.
- HDR, 8'hA5, frame start byte.
- BAUD_DEFAULT, 2'b00, baud_rate value after reset.
- PARITY_DEFAULT, 2'b00, parity_type value after reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_load  in  1  load cfg_baud_rate/cfg_parity_type (honoured only in IDLE).
- cfg_baud_rate  in  2  requested baud select.
- cfg_parity_type  in  2  requested parity select.
- baud_rate  out  2  to UART RX baud_rate.
- parity_type  out  2  to UART RX parity_type.
- rx_flag  in  1  receive flag from UART RX (asynchronous to clk domain usage; byte valid on its rising edge).
- rx_data  in  8  received byte, stable while rx_flag high.
- pkt_data  out  8  payload byte.
- pkt_valid  out  1  pkt_data valid.
- pkt_ready  in  1  sink accepts byte.
- pkt_last  out  1  marks final payload byte.
- frame_done  out  1  one-cycle pulse, good frame.
- frame_err  out  1  one-cycle pulse, frame rejected.
- err_code  out  2  valid with frame_err: 01 length, 10 checksum, 11 timeout.
- drop_cnt  out  8  saturating count of bytes dropped during DRAIN.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; baud_rate=BAUD_DEFAULT; parity_type=PARITY_DEFAULT.
  - pkt_valid, pkt_last, frame_done, frame_err = 0; err_code=00; pkt_data=0; drop_cnt=0.
  - Pointers, checksum and timer cleared.
  - Mid-frame reset discards everything.
- rx_flag handling:
  - 2-flop synchroniser followed by a rising-edge detect produces a 1-cycle internal byte_stb.
  - rx_data is sampled on the byte_stb cycle.
  - byte_stb occurs 3 clk cycles after rx_flag rises. A level held high yields one strobe only.
- Config:
  - cfg_load=1 in IDLE updates baud_rate/parity_type on the next edge.
  - cfg_load is ignored in all other states.
  - If cfg_load and byte_stb coincide in IDLE, both take effect.
- FSM states:
  - IDLE: byte_stb with data==HDR goes to LEN; any other byte is ignored.
  - LEN: on byte_stb, store len and set csum=data.
    - len>MAX_LEN: frame_err, err_code=01, go to IDLE.
    - len==0: go to CSUM.
    - Otherwise: go to PAYLOAD.
  - PAYLOAD: on byte_stb, write buf[wr_ptr], increment wr_ptr, csum^=data. After the len-th byte, go to CSUM.
  - CSUM: on byte_stb, compare data with csum.
    - Mismatch: frame_err, err_code=10, go to IDLE (buffer discarded).
    - Match with len==0: frame_done, go to IDLE.
    - Match with len>0: frame_done, go to DRAIN.
  - DRAIN:
    - pkt_valid=1 and pkt_data=buf[rd_ptr], registered; the first byte is valid the cycle after entering DRAIN.
    - A transfer occurs on pkt_valid&pkt_ready, then rd_ptr increments.
    - pkt_last=1 while rd_ptr==len-1.
    - Last transfer: pkt_valid drops the next cycle, go to IDLE.
    - pkt_data/pkt_valid must be held stable while pkt_valid&!pkt_ready.
    - byte_stb in DRAIN drops the byte and increments drop_cnt (saturates at 255).
- Timeout:
  - Timer clears on every byte_stb and counts clk cycles in LEN/PAYLOAD/CSUM.
  - On reaching TIMEOUT_CYC: frame_err, err_code=11, go to IDLE.
  - A byte_stb on the same cycle wins (no timeout).
  - Timer is inactive in IDLE and DRAIN.
- err_code: holds its last value until the next frame_err.
- frame_done and frame_err are never asserted together.

Test Plan:
- Good frame: bytes A5 03 11 22 33 03 -> frame_done pulse; with pkt_ready=1, pkt_data 11,22,33 on consecutive cycles, pkt_last only with 33, frame_err=0.
- Bad checksum: A5 02 10 20 31 (expected 32) -> frame_err with err_code=10, pkt_valid stays 0, FSM back in IDLE; the next good frame A5 01 55 54 drains 55.
- Length/zero-length: A5 11 (17>16) -> err_code=01, no payload; then A5 00 00 -> frame_done, pkt_valid never asserted.
- Timeout: A5 02 AA then silence -> frame_err err_code=11 exactly TIMEOUT_CYC cycles after AA's byte_stb; a byte arriving one cycle earlier is accepted normally.
- Backpressure/overrun: good frame of 4 bytes with pkt_ready toggling 1,0,0,1... -> data held stable while stalled, all 4 bytes delivered in order; 3 bytes sent during DRAIN -> drop_cnt=3.
- Config and reset: cfg_load with 2'b11/2'b01 in IDLE -> outputs update next cycle; cfg_load mid-PAYLOAD -> ignored; reset asserted mid-PAYLOAD -> all outputs at reset values immediately, and the next A5 frame is decoded correctly.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// Frame-level controller above the UART receiver. Owns the receiver's baud and
// parity configuration, parses HDR/LEN/payload/CSUM frames, buffers the payload
// and streams it out only after the XOR checksum has been verified.
module uart_rx_frame_ctrl #(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYC    = 100000,
  parameter logic [7:0]  HDR            = 8'hA5,
  parameter logic [1:0]  BAUD_DEFAULT   = 2'b00,
  parameter logic [1:0]  PARITY_DEFAULT = 2'b00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_load,
  input  logic [1:0] cfg_baud_rate,
  input  logic [1:0] cfg_parity_type,
  output logic [1:0] baud_rate,
  output logic [1:0] parity_type,
  input  logic       rx_flag,
  input  logic [7:0] rx_data,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] drop_cnt
);

  localparam int unsigned PtrW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TmrW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] MaxLen = 8'(MAX_LEN);

  typedef enum logic [2:0] {StIdle, StLen, StPayload, StCsum, StDrain} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic            byte_stb, in_frame, timeout, len_bad, csum_ok, last_wr;
  logic [7:0]      len_q, csum_q, wr_ptr_q, rd_ptr_q, rd_nxt, len_m1;
  logic [7:0]      buf_q [MAX_LEN];
  logic [TmrW-1:0] tmr_q;
  logic            frame_done_d, frame_err_d;
  logic [1:0]      err_code_d;

  assign byte_stb = rx_sync_q & ~rx_prev_q;
  assign in_frame = (state_q == StLen) || (state_q == StPayload) || (state_q == StCsum);
  // A strobe on the expiry cycle resets the timer, so it always beats the timeout.
  assign timeout  = in_frame && !byte_stb && (tmr_q == TmrLast);
  assign len_bad  = rx_data > MaxLen;
  assign csum_ok  = rx_data == csum_q;
  assign len_m1   = len_q - 8'd1;
  assign last_wr  = wr_ptr_q == len_m1;
  assign rd_nxt   = rd_ptr_q + 8'd1;

  // Synchronise rx_flag and keep one extra stage for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= rx_flag;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (byte_stb && rx_data == HDR) state_d = StLen;
      StLen: begin
        if (byte_stb) begin
          if (len_bad)              state_d = StIdle;
          else if (rx_data == 8'd0) state_d = StCsum;
          else                      state_d = StPayload;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StPayload: begin
        if (byte_stb && last_wr) state_d = StCsum;
        else if (timeout)        state_d = StIdle;
      end
      StCsum: begin
        if (byte_stb)     state_d = (csum_ok && len_q != 8'd0) ? StDrain : StIdle;
        else if (timeout) state_d = StIdle;
      end
      StDrain: if (pkt_valid && pkt_ready && pkt_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: next values of the frame status pulses and error code.
  always_comb begin
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code;
    unique case (state_q)
      StLen: begin
        if (byte_stb && len_bad) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'b01;
        end
      end
      StCsum: begin
        if (byte_stb && csum_ok) begin
          frame_done_d = 1'b1;
        end else if (byte_stb) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'b10;
        end
      end
      default: ;
    endcase
    if (timeout) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'b11;
    end
  end

  // Register the status outputs so they are glitch-free single-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      frame_done <= frame_done_d;
      frame_err  <= frame_err_d;
      err_code   <= err_code_d;
    end
  end

  // Frame datapath: length, running checksum, write pointer and inter-byte timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q    <= 8'd0;
      csum_q   <= 8'd0;
      wr_ptr_q <= 8'd0;
      tmr_q    <= '0;
    end else begin
      if (byte_stb || !in_frame) tmr_q <= '0;
      else                       tmr_q <= tmr_q + 1'b1;
      if (byte_stb && state_q == StLen) begin
        len_q    <= rx_data;
        csum_q   <= rx_data;
        wr_ptr_q <= 8'd0;
      end else if (byte_stb && state_q == StPayload) begin
        wr_ptr_q <= wr_ptr_q + 8'd1;
        csum_q   <= csum_q ^ rx_data;
      end
    end
  end

  // Payload buffer; contents are only meaningful below the write pointer.
  always_ff @(posedge clk) begin
    if (byte_stb && state_q == StPayload) buf_q[wr_ptr_q[PtrW-1:0]] <= rx_data;
  end

  // Output stream: the first byte is loaded one cycle into DRAIN, then advances on
  // each accepted transfer and holds while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_valid <= 1'b0;
      pkt_last  <= 1'b0;
      pkt_data  <= 8'd0;
      rd_ptr_q  <= 8'd0;
    end else if (state_q != StDrain) begin
      pkt_valid <= 1'b0;
      pkt_last  <= 1'b0;
      rd_ptr_q  <= 8'd0;
    end else if (!pkt_valid) begin
      pkt_valid <= 1'b1;
      pkt_data  <= buf_q[rd_ptr_q[PtrW-1:0]];
      pkt_last  <= rd_ptr_q == len_m1;
    end else if (pkt_ready) begin
      if (pkt_last) begin
        pkt_valid <= 1'b0;
        pkt_last  <= 1'b0;
        rd_ptr_q  <= 8'd0;
      end else begin
        rd_ptr_q <= rd_nxt;
        pkt_data <= buf_q[rd_nxt[PtrW-1:0]];
        pkt_last <= rd_nxt == len_m1;
      end
    end
  end

  // Receiver configuration, writable only between frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_rate   <= BAUD_DEFAULT;
      parity_type <= PARITY_DEFAULT;
    end else if (state_q == StIdle && cfg_load) begin
      baud_rate   <= cfg_baud_rate;
      parity_type <= cfg_parity_type;
    end
  end

  // Count bytes that arrive while the previous payload is still draining.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= 8'd0;
    end else if (state_q == StDrain && byte_stb && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frames from the test plan plus randomised
// frames whose expected outcome is derived from how each frame was built.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned MaxLen     = 16;
  localparam int unsigned TimeoutCyc = 40;

  typedef logic [7:0] bytes_t [$];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_load = 1'b0;
  logic [1:0] cfg_baud_rate = 2'b00;
  logic [1:0] cfg_parity_type = 2'b00;
  logic       rx_flag = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       pkt_ready;
  logic [1:0] baud_rate, parity_type, err_code;
  logic [7:0] pkt_data, drop_cnt;
  logic       pkt_valid, pkt_last, frame_done, frame_err;

  int n_checks = 0;
  int n_fail = 0;
  int ready_mode = 0;

  // Monitor log.
  logic [7:0] got_data [$];
  logic       got_last [$];
  int         got_cyc [$];
  int         cyc = 0;
  int         n_done = 0;
  int         n_err = 0;
  int         n_both = 0;
  int         n_valid = 0;
  int         n_stall_bad = 0;
  logic       pv_prev = 1'b0;
  logic       pr_prev = 1'b0;
  logic [7:0] pd_prev = 8'h00;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .MAX_LEN    (MaxLen),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_load       (cfg_load),
    .cfg_baud_rate  (cfg_baud_rate),
    .cfg_parity_type(cfg_parity_type),
    .baud_rate      (baud_rate),
    .parity_type    (parity_type),
    .rx_flag        (rx_flag),
    .rx_data        (rx_data),
    .pkt_data       (pkt_data),
    .pkt_valid      (pkt_valid),
    .pkt_ready      (pkt_ready),
    .pkt_last       (pkt_last),
    .frame_done     (frame_done),
    .frame_err      (frame_err),
    .err_code       (err_code),
    .drop_cnt       (drop_cnt)
  );

  // Sink: 0 always ready, 1 pattern 1,0,0, 2 random, 3 never ready.
  initial begin
    int ph;
    ph = 0;
    pkt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: pkt_ready = 1'b1;
        1: begin
          pkt_ready = (ph % 3 == 0);
          ph++;
        end
        2: pkt_ready = 1'($urandom_range(0, 1));
        default: pkt_ready = 1'b0;
      endcase
    end
  end

  // Observe the stream and status pulses away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (pkt_valid && pkt_ready) begin
      got_data.push_back(pkt_data);
      got_last.push_back(pkt_last);
      got_cyc.push_back(cyc);
    end
    if (pkt_valid) n_valid <= n_valid + 1;
    if (frame_done) n_done <= n_done + 1;
    if (frame_err) n_err <= n_err + 1;
    if (frame_done && frame_err) n_both <= n_both + 1;
    if (pv_prev && !pr_prev && (!pkt_valid || pkt_data !== pd_prev)) n_stall_bad <= n_stall_bad + 1;
    pv_prev <= pkt_valid;
    pr_prev <= pkt_ready;
    pd_prev <= pkt_data;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at 5 ms, required to finish");
    $fatal(1);
  end

  function automatic logic [31:0] got_word(input int base, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w = {w[23:0], (base + i < got_data.size()) ? got_data[base + i] : 8'hxx};
    return w;
  endfunction

  function automatic logic [3:0] got_lasts(input int base, input int n);
    logic [3:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w = {w[2:0], (base + i < got_last.size()) ? got_last[base + i] : 1'bx};
    return w;
  endfunction

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_flag = 1'b1;
    repeat (4) @(negedge clk);
    rx_flag = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_list(input bytes_t b);
    foreach (b[i]) send_byte(b[i]);
  endtask

  task automatic wait_xfers(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (got_data.size() < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (got_data.size() < target) begin
      n_fail++;
      $display("FAIL %s: %0d bytes delivered, %0d required", name, got_data.size(), target);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({baud_rate, parity_type} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_cfg: got %b, required 0000", {baud_rate, parity_type});
    end
    n_checks++;
    if ({pkt_valid, pkt_last, frame_done, frame_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 0000",
               {pkt_valid, pkt_last, frame_done, frame_err});
    end
    n_checks++;
    if ({err_code, pkt_data, drop_cnt} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, required 0", {err_code, pkt_data, drop_cnt});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    int bd, be, bg;
    ready_mode = 0;
    bd = n_done; be = n_err; bg = got_data.size();
    send_list('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    settle(10);
    n_checks++;
    if (n_done - bd != 1 || n_err != be) begin
      n_fail++;
      $display("FAIL good_status: done=%0d err=%0d, required done=1 err=0", n_done - bd, n_err - be);
    end
    n_checks++;
    if (got_word(bg, 3) !== 32'h00112233 || got_data.size() - bg != 3) begin
      n_fail++;
      $display("FAIL good_data: got %h (%0d bytes), required 112233", got_word(bg, 3),
               got_data.size() - bg);
    end
    n_checks++;
    if (got_lasts(bg, 3) !== 4'b0001) begin
      n_fail++;
      $display("FAIL good_last: got %b, required 0001", got_lasts(bg, 3));
    end
    n_checks++;
    if (got_cyc.size() < bg + 3 || got_cyc[bg + 2] - got_cyc[bg] != 2) begin
      n_fail++;
      $display("FAIL good_back_to_back: transfers not on consecutive cycles, required 3 in a row");
    end
  endtask

  task automatic test_bad_csum();
    int bd, be, bg, bv;
    bd = n_done; be = n_err; bv = n_valid;
    send_list('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31});
    settle(6);
    n_checks++;
    if (n_err - be != 1 || err_code !== 2'b10 || n_done != bd || n_valid != bv) begin
      n_fail++;
      $display("FAIL bad_csum: err=%0d code=%b done=%0d valid_cycles=%0d, required 1/10/0/0",
               n_err - be, err_code, n_done - bd, n_valid - bv);
    end
    bd = n_done; bg = got_data.size();
    send_list('{8'hA5, 8'h01, 8'h55, 8'h54});
    settle(8);
    n_checks++;
    if (n_done - bd != 1 || got_word(bg, 1) !== 32'h55 || got_lasts(bg, 1) !== 4'b0001) begin
      n_fail++;
      $display("FAIL after_bad_csum: done=%0d data=%h last=%b, required 1/55/1", n_done - bd,
               got_word(bg, 1), got_lasts(bg, 1));
    end
  endtask

  task automatic test_len();
    int bd, be, bv;
    bd = n_done; be = n_err; bv = n_valid;
    send_list('{8'hA5, 8'h11});
    settle(4);
    n_checks++;
    if (n_err - be != 1 || err_code !== 2'b01 || n_valid != bv) begin
      n_fail++;
      $display("FAIL len_too_long: err=%0d code=%b valid_cycles=%0d, required 1/01/0",
               n_err - be, err_code, n_valid - bv);
    end
    be = n_err;
    send_list('{8'hA5, 8'h00, 8'h00});
    settle(8);
    n_checks++;
    if (n_done - bd != 1 || n_err != be || n_valid != bv) begin
      n_fail++;
      $display("FAIL len_zero: done=%0d err=%0d valid_cycles=%0d, required 1/0/0", n_done - bd,
               n_err - be, n_valid - bv);
    end
  endtask

  task automatic test_timeout();
    int k, hit, bd, be, bg;
    logic saw;
    send_byte(8'hA5);
    send_byte(8'h02);
    @(negedge clk);
    rx_data = 8'hAA;
    rx_flag = 1'b1;
    k = 0;
    hit = -1;
    while (hit < 0 && k < 3 * TimeoutCyc) begin
      @(negedge clk);
      k++;
      if (k == 4) rx_flag = 1'b0;
      if (frame_err) hit = k;
    end
    // rx_flag rise -> byte_stb acted on 3 edges later, then TIMEOUT_CYC more edges.
    n_checks++;
    if (hit != int'(TimeoutCyc) + 3) begin
      n_fail++;
      $display("FAIL timeout_cycle: frame_err at edge %0d, required %0d", hit, TimeoutCyc + 3);
    end
    n_checks++;
    if (err_code !== 2'b11) begin
      n_fail++;
      $display("FAIL timeout_code: got %b, required 11", err_code);
    end
    settle(4);
    bd = n_done; be = n_err; bg = got_data.size();
    send_byte(8'hA5);
    send_byte(8'h02);
    @(negedge clk);
    rx_data = 8'hAA;
    rx_flag = 1'b1;
    saw = 1'b0;
    for (k = 1; k <= int'(TimeoutCyc) + 8; k++) begin
      @(negedge clk);
      if (k == 4) rx_flag = 1'b0;
      if (k == int'(TimeoutCyc)) begin
        rx_data = 8'hBB;
        rx_flag = 1'b1;
      end
      if (k == int'(TimeoutCyc) + 4) rx_flag = 1'b0;
      if (frame_err) saw = 1'b1;
    end
    send_byte(8'h13);
    settle(8);
    n_checks++;
    if (saw || n_err != be) begin
      n_fail++;
      $display("FAIL timeout_late_byte: frame_err seen=%0d, required 0", n_err - be);
    end
    n_checks++;
    if (n_done - bd != 1 || got_word(bg, 2) !== 32'h0000AABB) begin
      n_fail++;
      $display("FAIL timeout_late_frame: done=%0d data=%h, required 1/AABB", n_done - bd,
               got_word(bg, 2));
    end
  endtask

  task automatic test_backpressure();
    int bd, bg, bs;
    logic [7:0] dbase, cs;
    bytes_t pl;
    logic [31:0] exp_w;
    bd = n_done; bg = got_data.size(); bs = n_stall_bad; dbase = drop_cnt;
    cs = 8'h04;
    exp_w = '0;
    for (int i = 0; i < 4; i++) begin
      pl.push_back(8'($urandom));
      cs = cs ^ pl[i];
      exp_w = {exp_w[23:0], pl[i]};
    end
    ready_mode = 3;
    send_list({8'hA5, 8'h04, pl, cs});
    send_list('{8'h01, 8'h02, 8'h03});
    settle(2);
    n_checks++;
    if (drop_cnt !== dbase + 8'd3) begin
      n_fail++;
      $display("FAIL drop_cnt: got %0d, required %0d", drop_cnt, dbase + 8'd3);
    end
    ready_mode = 1;
    wait_xfers(bg + 4, 200, "bp_drain");
    settle(4);
    n_checks++;
    if (got_word(bg, 4) !== exp_w || got_lasts(bg, 4) !== 4'b0001 || n_done - bd != 1) begin
      n_fail++;
      $display("FAIL bp_data: got %h last %b done %0d, required %h last 0001 done 1",
               got_word(bg, 4), got_lasts(bg, 4), n_done - bd, exp_w);
    end
    n_checks++;
    if (n_stall_bad != bs) begin
      n_fail++;
      $display("FAIL bp_stable: %0d stall violations, required 0", n_stall_bad - bs);
    end
    ready_mode = 0;
  endtask

  task automatic test_config();
    int bd, bg;
    @(negedge clk);
    cfg_baud_rate = 2'b11;
    cfg_parity_type = 2'b01;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    n_checks++;
    if ({baud_rate, parity_type} !== 4'b1101) begin
      n_fail++;
      $display("FAIL cfg_idle: got %b, required 1101", {baud_rate, parity_type});
    end
    send_list('{8'hA5, 8'h03, 8'h11});
    cfg_baud_rate = 2'b00;
    cfg_parity_type = 2'b10;
    cfg_load = 1'b1;
    repeat (3) @(negedge clk);
    cfg_load = 1'b0;
    n_checks++;
    if ({baud_rate, parity_type} !== 4'b1101) begin
      n_fail++;
      $display("FAIL cfg_busy: got %b, required 1101", {baud_rate, parity_type});
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({baud_rate, parity_type, err_code, drop_cnt, pkt_data} !== 22'h0 ||
        {pkt_valid, pkt_last, frame_done, frame_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_frame: cfg=%b code=%b drop=%0d data=%h flags=%b, required zeros",
               {baud_rate, parity_type}, err_code, drop_cnt, pkt_data,
               {pkt_valid, pkt_last, frame_done, frame_err});
    end
    @(negedge clk);
    reset = 1'b1;
    bd = n_done; bg = got_data.size();
    send_list('{8'hA5, 8'h02, 8'h66, 8'h77, 8'h13});
    settle(8);
    n_checks++;
    if (n_done - bd != 1 || got_word(bg, 2) !== 32'h00006677) begin
      n_fail++;
      $display("FAIL after_reset: done=%0d data=%h, required 1/6677", n_done - bd,
               got_word(bg, 2));
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      int kind, len, bd, be, bg, bad;
      logic [7:0] b, cs;
      logic exp_done;
      logic [1:0] exp_code;
      bytes_t pl, fr;
      ready_mode = 2;
      bd = n_done; be = n_err; bg = got_data.size();
      // Idle noise that is not a header must be ignored.
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        fr.push_back(b);
      end
      kind = int'($urandom_range(0, 9));
      exp_code = 2'b00;
      if (kind == 0) begin
        b = 8'($urandom_range(MaxLen + 1, 255));
        fr.push_back(8'hA5);
        fr.push_back(b);
        exp_done = 1'b0;
        exp_code = 2'b01;
      end else begin
        len = int'($urandom_range(0, MaxLen));
        cs = 8'(len);
        fr.push_back(8'hA5);
        fr.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
          pl.push_back(8'($urandom));
          cs = cs ^ pl[i];
          fr.push_back(pl[i]);
        end
        exp_done = 1'b1;
        if (kind == 1) begin
          cs = cs ^ 8'($urandom_range(1, 255));
          exp_done = 1'b0;
          exp_code = 2'b10;
          pl.delete();
        end
        fr.push_back(cs);
      end
      send_list(fr);
      wait_xfers(bg + pl.size(), 600, "rand_drain");
      settle(4);
      n_checks++;
      if (n_done - bd != int'(exp_done) || n_err - be != int'(!exp_done) ||
          (!exp_done && err_code !== exp_code)) begin
        n_fail++;
        $display("FAIL rand_status[%0d]: done=%0d err=%0d code=%b, required done=%0d code=%b",
                 f, n_done - bd, n_err - be, err_code, exp_done, exp_code);
      end
      bad = (got_data.size() - bg != pl.size()) ? 1 : 0;
      for (int i = 0; i < pl.size() && bg + i < got_data.size(); i++) begin
        if (got_data[bg + i] !== pl[i] || got_last[bg + i] !== (i == pl.size() - 1)) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL rand_payload[%0d]: %0d bad bytes of %0d delivered, required %0d exact",
                 f, bad, got_data.size() - bg, pl.size());
      end
    end
    ready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len();
    test_timeout();
    test_backpressure();
    test_config();
    test_random();
    n_checks++;
    if (n_both != 0) begin
      n_fail++;
      $display("FAIL done_err_exclusive: %0d overlapping pulses, required 0", n_both);
    end
    n_checks++;
    if (n_stall_bad != 0) begin
      n_fail++;
      $display("FAIL stream_stable: %0d stall violations, required 0", n_stall_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
